circuito_fsm: RTL and testbench



---
 rtl/circuito_pkg.sv | 21 ++
 rtl/circuito_if.sv | 18 +
 rtl/circuito_sym_match.sv | 20 ++
 rtl/circuito_fsm.sv | 113 +++++++++++
 tb/tb_circuito_fsm.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/circuito_pkg.sv
// Shared types and constants for the circuito symbol-sequence lock.
// State codes are the visible {a,b,c,d} display value.
package circuito_pkg;

    localparam int SYM_W = 7;

    localparam logic [SYM_W-1:0] K1_DEF = 7'h0C;
    localparam logic [SYM_W-1:0] K2_DEF = 7'h24;
    localparam logic [SYM_W-1:0] K3_DEF = 7'h30;

    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [3:0] {
        IDLE  = 4'b0000,
        S1    = 4'b0101,
        S2    = 4'b0110,
        OPEN  = 4'b0111,
        ERROR = 4'b1000
    } state_t;

endpackage

// File: rtl/circuito_if.sv
// Keyed-input / status-display bundle for the circuito lock.
interface circuito_if;

    logic b8;
    logic b7, b6, b5, b4, b3, b2, b1;
    logic a, b, c, d;

    modport master (
        output b8, b7, b6, b5, b4, b3, b2, b1,
        input  a, b, c, d
    );

    modport slave (
        input  b8, b7, b6, b5, b4, b3, b2, b1,
        output a, b, c, d
    );

endinterface

// File: rtl/circuito_sym_match.sv
// Combinational key comparator; flags are qualified by the valid strobe.
import circuito_pkg::*;

module circuito_sym_match #(
    parameter logic [SYM_W-1:0] K1 = K1_DEF,
    parameter logic [SYM_W-1:0] K2 = K2_DEF,
    parameter logic [SYM_W-1:0] K3 = K3_DEF
) (
    input  logic [SYM_W-1:0] sym,
    input  logic             b8,
    output logic             is_k1,
    output logic             is_k2,
    output logic             is_k3
);

    assign is_k1 = b8 && (sym == K1);
    assign is_k2 = b8 && (sym == K2);
    assign is_k3 = b8 && (sym == K3);

endmodule

// File: rtl/circuito_fsm.sv
// Symbol-sequence lock FSM; {a,b,c,d} is the registered state code.
// Optional ERROR auto-clear after TIMEOUT cycles when CIRCUITO_AUTOCLR_EN is defined.
import circuito_pkg::*;

module circuito_fsm #(
    parameter logic [SYM_W-1:0] K1      = K1_DEF,
    parameter logic [SYM_W-1:0] K2      = K2_DEF,
    parameter logic [SYM_W-1:0] K3      = K3_DEF,
    parameter int               TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    circuito_if.slave   bus
);

    // state | meaning
    // IDLE  | waiting for K1
    // S1    | K1 accepted, waiting for K2 (K1 repeat holds)
    // S2    | K2 accepted, waiting for K3 (K2 repeat holds)
    // OPEN  | unlocked, sticky until reset
    // ERROR | wrong symbol seen, sticky (or timed clear)

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("circuito_fsm: TIMEOUT out of range 1..255");
    end

    state_t           state;
    logic [SYM_W-1:0] sym;
    logic             is_k1, is_k2, is_k3;

    assign sym = {bus.b7, bus.b6, bus.b5, bus.b4, bus.b3, bus.b2, bus.b1};

    circuito_sym_match #(
        .K1 (K1),
        .K2 (K2),
        .K3 (K3)
    ) u_match (
        .sym   (sym),
        .b8    (bus.b8),
        .is_k1 (is_k1),
        .is_k2 (is_k2),
        .is_k3 (is_k3)
    );

`ifdef CIRCUITO_AUTOCLR_EN
    localparam logic [7:0] ERR_TC = 8'(TIMEOUT - 1);
    logic [7:0] err_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
`ifdef CIRCUITO_AUTOCLR_EN
            err_cnt <= '0;
`endif
        end else begin
`ifdef CIRCUITO_AUTOCLR_EN
            // held at zero outside ERROR so every entry starts a fresh count
            if (state != ERROR) begin
                err_cnt <= '0;
            end
`endif
            case (state)
                IDLE: begin
                    if (bus.b8) begin
                        state <= is_k1 ? S1 : ERROR;
                    end
                end
                S1: begin
                    if (bus.b8) begin
                        if (is_k2) begin
                            state <= S2;
                        end else if (!is_k1) begin
                            state <= ERROR;
                        end
                    end
                end
                S2: begin
                    if (bus.b8) begin
                        if (is_k3) begin
                            state <= OPEN;
                        end else if (!is_k2) begin
                            state <= ERROR;
                        end
                    end
                end
                OPEN: begin
                    state <= OPEN;
                end
                ERROR: begin
`ifdef CIRCUITO_AUTOCLR_EN
                    if (err_cnt == ERR_TC) begin
                        state <= IDLE;
                    end else begin
                        err_cnt <= err_cnt + 8'd1;
                    end
`else
                    state <= ERROR;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a = state[3];
    assign bus.b = state[2];
    assign bus.c = state[1];
    assign bus.d = state[0];

endmodule

// File: tb/tb_circuito_fsm.sv
// Self-checking bench for circuito_fsm: directed test plan plus randomized
// traffic against a progress-index reference model.
module tb_circuito_fsm;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    circuito_if bus ();

    circuito_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: how many keys of the sequence have been accepted,
    // whether the lock is tripped, and how many error cycles remain.
    logic [6:0] keys [3] = '{7'h0C, 7'h24, 7'h30};
    int  progress = 0;
    bit  tripped  = 1'b0;
    int  err_left = 0;

    function automatic logic [3:0] model_code();
        if (tripped) return 4'b1000;
        case (progress)
            0: return 4'b0000;
            1: return 4'b0101;
            2: return 4'b0110;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic model_step(input logic [7:0] v, input bit rst);
        logic [6:0] s;
        s = v[6:0];
        if (rst) begin
            progress = 0;
            tripped  = 1'b0;
            err_left = 0;
        end else if (tripped) begin
`ifdef CIRCUITO_AUTOCLR_EN
            err_left--;
            if (err_left == 0) begin
                tripped  = 1'b0;
                progress = 0;
            end
`endif
        end else if (v[7] && progress < 3) begin
            if (s == keys[progress]) begin
                progress++;
            end else if (!(progress > 0 && s == keys[progress-1])) begin
                tripped  = 1'b1;
                err_left = TO;
            end
        end
    endtask

    function automatic logic [3:0] dut_code();
        return {bus.a, bus.b, bus.c, bus.d};
    endfunction

    task automatic chk(input string tag, input logic [3:0] exp);
        checks++;
        assert (dut_code() === exp) else begin
            errors++;
            $error("FAIL %s abcd=%b expected=%b", tag, dut_code(), exp);
        end
    endtask

    // Drive one input pattern, clock it, update the model, compare.
    task automatic step(input logic [7:0] v, input bit rst, input string tag);
        @(negedge clk);
        reset = rst;
        {bus.b8, bus.b7, bus.b6, bus.b5, bus.b4, bus.b3, bus.b2, bus.b1} = v;
        @(posedge clk);
        model_step(v, rst);
        #1;
        chk(tag, model_code());
    endtask

    initial begin
        int n;
        reset = 1'b1;
        {bus.b8, bus.b7, bus.b6, bus.b5, bus.b4, bus.b3, bus.b2, bus.b1} = 8'h00;

        // 1: reset, then K1
        step(8'h00, 1'b1, "reset");          chk("reset_const", 4'b0000);
        step(8'h8C, 1'b0, "k1");             chk("k1_const", 4'b0101);

        // 2: wrong symbol from S1, hold, reset
        step(8'hD8, 1'b0, "s1_wrong");       chk("s1_wrong_const", 4'b1000);
        for (int i = 0; i < 3; i++) step(8'hD8, 1'b0, "err_hold");
        chk("err_hold_const", 4'b1000);
        step(8'hD8, 1'b1, "err_reset");      chk("err_reset_const", 4'b0000);

        // 3: K1 repeats and invalid strobe hold S1
        step(8'h8C, 1'b0, "k1_again");
        step(8'h8C, 1'b0, "k1_rep1");
        step(8'h8C, 1'b0, "k1_rep2");        chk("k1_rep_const", 4'b0101);
        step(8'h0C, 1'b0, "no_strobe");      chk("no_strobe_const", 4'b0101);
        step(8'h00, 1'b1, "reset3");

        // 4: full unlock, OPEN is sticky
        step(8'h8C, 1'b0, "seq_k1");         chk("seq_k1_const", 4'b0101);
        step(8'hA4, 1'b0, "seq_k2");         chk("seq_k2_const", 4'b0110);
        step(8'hB0, 1'b0, "seq_k3");         chk("seq_k3_const", 4'b0111);
        step(8'hD8, 1'b0, "open_hold1");
        step(8'h8C, 1'b0, "open_hold2");     chk("open_hold_const", 4'b0111);
        step(8'h00, 1'b1, "open_reset");     chk("open_reset_const", 4'b0000);

        // 5: wrong symbols from IDLE and S2; reset beats a correct key
        step(8'hEB, 1'b0, "idle_wrong");     chk("idle_wrong_const", 4'b1000);
        step(8'h00, 1'b1, "reset5a");
        step(8'h8C, 1'b0, "s2_path_k1");
        step(8'hA4, 1'b0, "s2_path_k2");
        step(8'hA4, 1'b0, "k2_repeat");      chk("k2_repeat_const", 4'b0110);
        step(8'hB2, 1'b0, "s2_wrong");       chk("s2_wrong_const", 4'b1000);
        step(8'h00, 1'b1, "reset5b");
        step(8'h8C, 1'b1, "reset_vs_k1");    chk("reset_vs_k1_const", 4'b0000);

        // 6: ERROR duration
        step(8'hEB, 1'b0, "enter_err");
        n = 1;
`ifdef CIRCUITO_AUTOCLR_EN
        while (dut_code() == 4'b1000 && n < 300) begin
            step(8'h00, 1'b0, "autoclr_run");
            if (dut_code() == 4'b1000) n++;
        end
        checks++;
        assert (n == TO) else begin
            errors++;
            $error("FAIL err_duration cycles=%0d expected=%0d", n, TO);
        end
        chk("autoclr_idle", 4'b0000);
`else
        for (int i = 0; i < 100; i++) step(8'h00, 1'b0, "err_sticky_run");
        chk("err_sticky_100", 4'b1000);
`endif

        // Randomized traffic biased toward the key symbols.
        step(8'h00, 1'b1, "rand_reset");
        for (int i = 0; i < 600; i++) begin
            logic [7:0] v;
            bit         r;
            int         pick;
            pick = $urandom_range(0, 9);
            if (pick < 7) v[6:0] = keys[pick % 3];
            else          v[6:0] = 7'($urandom);
            v[7] = ($urandom_range(0, 3) != 0);
            r    = ($urandom_range(0, 39) == 0);
            step(v, r, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
